// File: rtl/valu_pipe_lxn.sv
// Pipelined L-lane x N-bit vector ALU with valid/ready handshakes.
// Element-wise, scalar-broadcast and rotate finish in one cycle; reduce folds over L-1 cycles.
module valu_pipe_lxn #(
    parameter int unsigned N = 32,
    parameter int unsigned L = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     mode,
    input  logic [3:0]     alu_op,
    input  logic [L-1:0]   lane_mask,
    input  logic [L*N-1:0] operand_0_bus,
    input  logic [L*N-1:0] operand_1_bus,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [L*N-1:0] result_bus,
    output logic           busy
);

    localparam int unsigned SW = $clog2(N);
    localparam int unsigned LW = $clog2(L);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REDUCE = 2'd1;
    localparam logic [1:0] ST_FULL   = 2'd2;

    localparam logic [1:0] MODE_ELEM   = 2'b00;
    localparam logic [1:0] MODE_BCAST  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;
    localparam logic [1:0] MODE_REDUCE = 2'b11;

    logic [1:0]     state_q, state_d;
    logic [L*N-1:0] result_q, result_d;
    logic [L*N-1:0] opnd_q, opnd_d;
    logic [3:0]     op_q, op_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [LW-1:0]  idx_q, idx_d;

    logic           accept;
    logic [L*N-1:0] lane_result;
    logic [N-1:0]   lane_a, lane_b, step;
    logic [LW-1:0]  rot_amt, rot_src;

    function automatic logic [N-1:0] lane_op(input logic [3:0] op, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
        logic [SW-1:0] sh;
        logic [N-1:0]  r;
        sh = b[SW-1:0];
        r  = '0;
        case (op)
            4'b0000: r = a + b;
            4'b0001: r = a - b;
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b0100: r = a ^ b;
            4'b0101: r = a << sh;
            4'b0110: r = a >> sh;
            4'b0111: r = $signed(a) >>> sh;
            4'b1000: r = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b1001: r = {{(N-1){1'b0}}, (a < b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign out_valid  = (state_q == ST_FULL);
    assign busy       = (state_q == ST_REDUCE);
    assign in_ready   = (state_q != ST_REDUCE) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign result_bus = result_q;

    // Single-cycle datapath for modes 00-10.
    always_comb begin
        lane_result = '0;
        lane_a      = '0;
        lane_b      = '0;
        rot_src     = '0;
        rot_amt     = operand_0_bus[LW-1:0];
        for (int i = 0; i < int'(L); i++) begin
            if (mode == MODE_ROTATE) begin
                rot_src = LW'(i) + rot_amt;
                lane_result[i*N +: N] = operand_1_bus[rot_src*N +: N];
            end else begin
                lane_a = (mode == MODE_BCAST) ? operand_0_bus[N-1:0] : operand_0_bus[i*N +: N];
                lane_b = operand_1_bus[i*N +: N];
                lane_result[i*N +: N] = lane_mask[i] ? lane_op(alu_op, lane_a, lane_b) : lane_a;
            end
        end
    end

    assign step = lane_op(op_q, acc_q, opnd_q[idx_q*N +: N]);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        case (state_q)
            ST_IDLE, ST_FULL: begin
                if (accept) begin
                    if (mode == MODE_REDUCE) begin
                        state_d = ST_REDUCE;
                        opnd_d  = operand_0_bus;
                        op_d    = alu_op;
                        acc_d   = operand_0_bus[N-1:0];
                        idx_d   = LW'(1);
                    end else begin
                        state_d  = ST_FULL;
                        result_d = lane_result;
                    end
                end else if (state_q == ST_FULL && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_REDUCE: begin
                acc_d = step;
                idx_d = idx_q + LW'(1);
                if (idx_q == LW'(L - 1)) begin
                    state_d           = ST_FULL;
                    result_d          = '0;
                    result_d[N-1:0]   = step;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            opnd_q   <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
        end
    end

endmodule
